top_top_module: RTL and testbench
=================================

TOP_TOP_MODULE -- requirements
Module: top_top_module

Interface
REQ-001 SHALL have parameter W, default 32: data width of incoming_data, final_result and the internal coefficient storage.
REQ-002 SHALL have parameter Q, default 17: NTT prime modulus; SHALL satisfy 2 < Q < 2^(W-1) and (Q-1) divisible by 8.
REQ-003 SHALL have parameter OMEGA, default 2: primitive 8th root of unity mod Q, so OMEGA^4 = Q-1 mod Q.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port incoming_data, input, W bits: one time-domain sample per clock during the load phase.
REQ-007 SHALL have port final_result, output, W bits, registered: one NTT coefficient per clock during the unload phase, otherwise 0.

Function
REQ-008 SHALL compute an 8-point forward NTT over Z_Q: X[k] = sum over n=0..7 of x[n]*OMEGA^(n*k) mod Q.
REQ-009 SHALL have no handshake; framing is set purely by the cycle count from reset release.
REQ-010 SHALL use an FSM with states LOAD -> COMPUTE -> UNLOAD -> LOAD, repeating frames indefinitely.
REQ-011 Edges are numbered with edge 1 as the first rising edge at which rst is low.
REQ-012 LOAD: SHALL capture incoming_data on edges 1..8 as x[0]..x[7]; each sample is reduced mod Q and stored at bit-reversed address (n -> {n0,n1,n2}).
REQ-013 COMPUTE: SHALL take exactly 12 cycles (edges 9..20), one radix-2 DIT butterfly per cycle; stages m=1,2,4 run in order, 4 butterflies per stage.
REQ-014 Each butterfly SHALL operate on pair (i, i+m) with twiddle w = OMEGA^((4/m)*j), where j = i mod m.
REQ-015 Butterfly outputs SHALL be a' = (a + w*b) mod Q and b' = (a - w*b) mod Q; results are written back in place on the same edge.
REQ-016 The product w*b SHALL be formed at 2W bits before reduction; every stored value SHALL stay in [0, Q-1]; subtraction SHALL wrap by adding Q, never going negative.
REQ-017 Twiddles OMEGA^0..OMEGA^3 mod Q SHALL be derived from the parameters at elaboration, never from hard-coded literals.
REQ-018 UNLOAD: on edges 21..28 final_result SHALL be loaded with X[0]..X[7] in natural order, so X[k] is visible in the cycle after edge 21+k.
REQ-019 On edge 29 final_result SHALL return to 0; the FSM SHALL re-enter LOAD, and edge 29 captures sample 0 of the next frame (period 28 cycles).
REQ-020 final_result SHALL be 0 throughout LOAD and COMPUTE.
REQ-021 Changes on incoming_data outside LOAD SHALL be ignored.

Reset
REQ-022 rst sampled high on any edge SHALL force state LOAD, sample/butterfly/output counters to 0, and final_result to 0, regardless of current phase.
REQ-023 A reset mid-frame SHALL discard the partial frame; the next edge with rst low becomes edge 1 of a new frame.
REQ-024 Coefficient storage need not be cleared by reset.

Verification
REQ-025 Reset rst=1 for one edge, then inputs 1,2,3,4,5,6,7,8 on edges 1..8 (Q=17, OMEGA=2) -> final_result = 2,8,14,6,13,3,12,1 after edges 21..28, and 0 before and after.
REQ-026 After the REQ-025 frame, hold inputs at 0 -> second frame outputs all 0 after edges 49..56; final_result stays 0 throughout.
REQ-027 Impulse input 1,0,0,0,0,0,0,0 -> all eight outputs equal 1.
REQ-028 Constant input 5 (all eight samples) -> X[0] = 40 mod 17 = 6, X[1..7] = 0.
REQ-029 Input 20 (≥ Q) on all eight samples -> treated as 3, giving X[0] = 24 mod 17 = 7, X[1..7] = 0.
REQ-030 Assert rst during COMPUTE (edge 15), then reload the REQ-025 data -> REQ-025 results appear at the new edges 21..28 with no stale outputs; final_result is 0 in the cycle after the reset edge.

Source files
------------

// File: rtl/top_top_module.sv
// 8-point forward NTT over Z_Q, free-running frames:
// load 8 samples, 12 in-place DIT butterflies, unload 8 coefficients.
module top_top_module #(
  parameter int W     = 32,
  parameter int Q     = 17,
  parameter int OMEGA = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] incoming_data,
  output logic [W-1:0] final_result
);

  localparam int W2 = 2 * W;

  // Elaboration-time OMEGA^e mod Q, computed at double width.
  function automatic logic [W-1:0] f_pow(input int e);
    logic [W2-1:0] acc;
    acc = W2'(1);
    for (int k = 0; k < e; k++) begin
      acc = (acc * W2'(OMEGA)) % W2'(Q);
    end
    return acc[W-1:0];
  endfunction

  localparam logic [W-1:0]  QW  = W'(Q);
  localparam logic [W2-1:0] QW2 = W2'(Q);
  localparam logic [W-1:0]  TW0 = f_pow(0);
  localparam logic [W-1:0]  TW1 = f_pow(1);
  localparam logic [W-1:0]  TW2 = f_pow(2);
  localparam logic [W-1:0]  TW3 = f_pow(3);

  typedef enum logic [1:0] {
    S_LOAD,
    S_COMPUTE,
    S_UNLOAD
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_cnt;
  logic          w_last;
  logic [W-1:0]  r_mem [8];

  logic [2:0]    w_ia;
  logic [2:0]    w_ib;
  logic [1:0]    w_e;
  logic [W-1:0]  w_tw;
  logic [W-1:0]  w_a;
  logic [W-1:0]  w_b;
  logic [W2-1:0] w_prod;
  logic [W2-1:0] w_prod_mod;
  logic [W-1:0]  w_wb;
  logic [W-1:0]  w_sum;
  logic [W-1:0]  w_add;
  logic [W-1:0]  w_sub;
  logic [2:0]    w_rev;
  logic [W-1:0]  w_in_mod;

  // Phase length check and next-state selection.
  always_comb begin
    w_last = 1'b0;
    w_next = r_state;
    unique case (r_state)
      S_LOAD: begin
        w_last = (r_cnt == 4'd7);
        if (w_last) w_next = S_COMPUTE;
      end
      S_COMPUTE: begin
        w_last = (r_cnt == 4'd11);
        if (w_last) w_next = S_UNLOAD;
      end
      S_UNLOAD: begin
        w_last = (r_cnt == 4'd7);
        if (w_last) w_next = S_LOAD;
      end
      default: w_next = S_LOAD;
    endcase
  end

  // State register and phase counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_LOAD;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_last ? 4'd0 : r_cnt + 4'd1;
    end
  end

  // Butterfly pair and twiddle exponent: stage from cnt[3:2], index from cnt[1:0].
  always_comb begin
    w_ia = '0;
    w_ib = '0;
    w_e  = '0;
    unique case (r_cnt[3:2])
      2'd0: begin
        w_ia = {r_cnt[1:0], 1'b0};
        w_ib = {r_cnt[1:0], 1'b1};
        w_e  = 2'd0;
      end
      2'd1: begin
        w_ia = {r_cnt[1], 1'b0, r_cnt[0]};
        w_ib = {r_cnt[1], 1'b1, r_cnt[0]};
        w_e  = {r_cnt[0], 1'b0};
      end
      2'd2: begin
        w_ia = {1'b0, r_cnt[1:0]};
        w_ib = {1'b1, r_cnt[1:0]};
        w_e  = r_cnt[1:0];
      end
      default: begin
        w_ia = '0;
        w_ib = '0;
        w_e  = '0;
      end
    endcase
  end

  // Modular butterfly datapath; all operands stay in [0, Q-1].
  always_comb begin
    unique case (w_e)
      2'd0:    w_tw = TW0;
      2'd1:    w_tw = TW1;
      2'd2:    w_tw = TW2;
      default: w_tw = TW3;
    endcase
    w_a        = r_mem[w_ia];
    w_b        = r_mem[w_ib];
    w_prod     = {{W{1'b0}}, w_tw} * {{W{1'b0}}, w_b};
    w_prod_mod = w_prod % QW2;
    w_wb       = w_prod_mod[W-1:0];
    w_sum      = w_a + w_wb;
    w_add      = (w_sum >= QW) ? w_sum - QW : w_sum;
    w_sub      = (w_a >= w_wb) ? w_a - w_wb : w_a + QW - w_wb;
    w_rev      = {r_cnt[0], r_cnt[1], r_cnt[2]};
    w_in_mod   = incoming_data % QW;
  end

  // Coefficient storage: bit-reversed load, in-place butterflies.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == S_LOAD) begin
        r_mem[w_rev] <= w_in_mod;
      end else if (r_state == S_COMPUTE) begin
        r_mem[w_ia] <= w_add;
        r_mem[w_ib] <= w_sub;
      end
    end
  end

  // Output register: coefficients in natural order during unload, else 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      final_result <= '0;
    end else if (r_state == S_UNLOAD) begin
      final_result <= r_mem[r_cnt[2:0]];
    end else begin
      final_result <= '0;
    end
  end

endmodule

// File: tb/tb_top_top_module.sv
// Bench for top_top_module: directed and random frames checked
// against a direct O(N^2) NTT sum, including mid-frame reset.
module tb_top_top_module;

  localparam int W     = 32;
  localparam int Q     = 17;
  localparam int OMEGA = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] incoming_data = '0;
  logic [W-1:0] final_result;

  int n_vec  = 0;
  int n_fail = 0;

  typedef logic [W-1:0] frame_t [8];

  always #5 clk = ~clk;

  top_top_module #(
    .W(W),
    .Q(Q),
    .OMEGA(OMEGA)
  ) dut (
    .clk(clk),
    .rst(rst),
    .incoming_data(incoming_data),
    .final_result(final_result)
  );

  task automatic check(input string tag, input logic [W-1:0] exp);
    n_vec++;
    assert (final_result === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d want %0d", tag, final_result, exp);
    end
  endtask

  function automatic longint ref_coef(input frame_t xs, input int k);
    longint acc;
    longint w;
    acc = 0;
    for (int n = 0; n < 8; n++) begin
      w = 1;
      for (int t = 0; t < n * k; t++) w = (w * OMEGA) % Q;
      acc = (acc + (longint'({32'd0, xs[n]}) % Q) * w) % Q;
    end
    return acc;
  endfunction

  function automatic frame_t ref_ntt(input frame_t xs);
    frame_t r;
    for (int k = 0; k < 8; k++) r[k] = W'(ref_coef(xs, k));
    return r;
  endfunction

  task automatic run_frame(input string tag, input frame_t xs,
                           input frame_t exp);
    for (int e = 1; e <= 28; e++) begin
      incoming_data = (e <= 8) ? xs[e-1] : W'($urandom);
      @(posedge clk);
      #1;
      check($sformatf("%s_e%0d", tag, e), (e >= 21) ? exp[e-21] : '0);
    end
  endtask

  frame_t seq_x, seq_exp, xs;

  initial begin
    seq_x   = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
    seq_exp = '{32'd2, 32'd8, 32'd14, 32'd6, 32'd13, 32'd3, 32'd12, 32'd1};

    rst = 1'b1;
    incoming_data = W'($urandom);
    @(posedge clk);
    #1;
    check("reset", '0);
    rst = 1'b0;

    run_frame("seq", seq_x, seq_exp);

    for (int n = 0; n < 8; n++) xs[n] = '0;
    run_frame("zero", xs, ref_ntt(xs));

    xs[0] = 32'd1;
    run_frame("impulse", xs, ref_ntt(xs));

    for (int n = 0; n < 8; n++) xs[n] = 32'd5;
    run_frame("const5", xs, ref_ntt(xs));

    for (int n = 0; n < 8; n++) xs[n] = 32'd20;
    run_frame("const20", xs, ref_ntt(xs));

    for (int f = 0; f < 4; f++) begin
      for (int n = 0; n < 8; n++) xs[n] = W'($urandom);
      run_frame($sformatf("rnd%0d", f), xs, ref_ntt(xs));
    end

    for (int f = 0; f < 2; f++) begin
      for (int n = 0; n < 8; n++) xs[n] = W'($urandom_range(Q - 1, 0));
      run_frame($sformatf("rndq%0d", f), xs, ref_ntt(xs));
    end

    for (int e = 1; e <= 14; e++) begin
      incoming_data = (e <= 8) ? seq_x[e-1] : W'($urandom);
      @(posedge clk);
      #1;
      check($sformatf("part_e%0d", e), '0);
    end
    rst = 1'b1;
    incoming_data = W'($urandom);
    @(posedge clk);
    #1;
    check("midrst", '0);
    rst = 1'b0;
    run_frame("after_rst", seq_x, seq_exp);

    for (int e = 1; e <= 22; e++) begin
      incoming_data = (e <= 8) ? seq_x[e-1] : W'($urandom);
      @(posedge clk);
      #1;
      check($sformatf("part2_e%0d", e), (e >= 21) ? seq_exp[e-21] : '0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("unload_rst", '0);
    rst = 1'b0;
    for (int n = 0; n < 8; n++) xs[n] = W'($urandom);
    run_frame("post_unload_rst", xs, ref_ntt(xs));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
